// File: rtl/pooled_frame_collector.sv
// Frame sink for a conv/pooling layer: stride-decimates raster-order window results into a
// local frame memory, then drains the frame downstream over a valid/ready handshake.
module pooled_frame_collector #(
    parameter int D_WIDTH     = 16,
    parameter int CHANNELS    = 4,
    parameter int FILTER_SIZE = 2,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        in_valid,
    input  logic [D_WIDTH*CHANNELS-1:0] in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [D_WIDTH*CHANNELS-1:0] out_data,
    output logic                        out_last,
    output logic                        frame_ready,
    output logic                        overrun
);
    localparam int WIN      = IMAGE_SIZE - FILTER_SIZE + 1;
    localparam int OUT_SIZE = (WIN - 1) / STRIDE + 1;
    localparam int DEPTH    = OUT_SIZE * OUT_SIZE;
    localparam int DW       = D_WIDTH * CHANNELS;
    localparam int RW       = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [RW-1:0] POS_LAST = RW'(WIN - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t          state_r;
    logic [RW-1:0]   row_r;
    logic [RW-1:0]   col_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [DW-1:0]   mem_r [DEPTH];

    logic            beat_s;
    logic            keep_s;
    logic            col_end_s;
    logic            frame_end_s;
    logic            wr_en_s;
    logic [PW-1:0]   rd_next_s;

    assign beat_s      = clk_en && in_valid;
    assign keep_s      = ((32'(row_r) % STRIDE) == 0) && ((32'(col_r) % STRIDE) == 0);
    assign col_end_s   = (col_r == POS_LAST);
    assign frame_end_s = col_end_s && (row_r == POS_LAST);
    assign wr_en_s     = !rst && (state_r == COLLECT) && beat_s && keep_s;
    assign rd_next_s   = rd_ptr_r + 1'b1;

    // Frame memory write port; contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Collect/drain controller with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= COLLECT;
            row_r       <= '0;
            col_r       <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            out_data    <= '0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (beat_s) begin
                        if (frame_end_s) begin
                            state_r     <= DRAIN;
                            frame_ready <= 1'b1;
                            in_ready    <= 1'b0;
                            row_r       <= '0;
                            col_r       <= '0;
                            wr_ptr_r    <= '0;
                        end else begin
                            if (col_end_s) begin
                                col_r <= '0;
                                row_r <= row_r + 1'b1;
                            end else begin
                                col_r <= col_r + 1'b1;
                            end
                            if (keep_s) begin
                                wr_ptr_r <= wr_ptr_r + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Upstream ignored in_ready: drop the beat but remember it happened.
                    if (beat_s) begin
                        overrun <= 1'b1;
                    end
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= mem_r[PW'(0)];
                        rd_ptr_r  <= '0;
                        out_last  <= (PTR_LAST == PW'(0));
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            frame_ready <= 1'b0;
                            in_ready    <= 1'b1;
                            rd_ptr_r    <= '0;
                            state_r     <= COLLECT;
                        end else begin
                            rd_ptr_r <= rd_next_s;
                            out_data <= mem_r[rd_next_s];
                            out_last <= (rd_next_s == PTR_LAST);
                        end
                    end
                end
                default: begin
                    state_r <= COLLECT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pooled_frame_collector.sv
// Directed bench for pooled_frame_collector on a 4x4 image, 2x2 filter, stride 2:
// kept beats are queued as the frame is streamed and popped as the drain hands them over.
module tb_pooled_frame_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_ready;
    logic       overrun;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    localparam int WIN = 3;

    pooled_frame_collector #(
        .D_WIDTH(8), .CHANNELS(1), .FILTER_SIZE(2), .IMAGE_SIZE(4), .STRIDE(2)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_ready(frame_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    // Streams n beats base..base+n-1; optional clk_en=0 decoy cycles before each beat.
    task automatic send_frame(input logic [7:0] base, input int n, input bit push, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                clk_en = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
                @(negedge clk);
            end
            clk_en = 1'b1; in_valid = 1'b1; in_data = base + 8'(i);
            if (push && (((i / WIN) % 2) == 0) && (((i % WIN) % 2) == 0))
                exp_q.push_back(base + 8'(i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        clk_en   = 1'b1;
    endtask

    // mode 0: out_ready always high; mode 1: pattern 1,0,0 repeating. inject drives beats during drain.
    task automatic drain(input int mode, input bit inject);
        int k    = 0;
        bit done = 1'b0;
        check("entry_frame_ready", 32'(frame_ready), 32'd1);
        check("entry_in_ready", 32'(in_ready), 32'd0);
        while (!done && k < 64) begin
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            in_valid  = inject;
            clk_en    = 1'b1;
            in_data   = 8'hAA;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
                    check("frame_ready_drain", 32'(frame_ready), 32'd1);
                    if (out_ready) begin
                        done = (exp_q.size() == 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
            k++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_done", 32'(done), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_frame_ready", 32'(frame_ready), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1 basic frame
        send_frame(8'd0, 9, 1'b1, 1'b0);
        drain(0, 1'b0);
        check("t1_overrun", 32'(overrun), 32'd0);

        // T2 stalled drain
        send_frame(8'd0, 9, 1'b1, 1'b0);
        drain(1, 1'b0);

        // T3 clk_en gaps
        send_frame(8'd0, 9, 1'b1, 1'b1);
        drain(0, 1'b0);
        check("t3_overrun", 32'(overrun), 32'd0);

        // T4 beats offered during drain
        send_frame(8'd0, 9, 1'b1, 1'b0);
        drain(0, 1'b1);
        check("t4_overrun", 32'(overrun), 32'd1);
        send_frame(8'd20, 9, 1'b1, 1'b0);
        drain(1, 1'b0);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);

        // T5 reset mid-frame
        send_frame(8'd50, 5, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'd0, 9, 1'b1, 1'b0);
        drain(0, 1'b0);

        // T6 back-to-back frames
        send_frame(8'd0, 9, 1'b1, 1'b0);
        drain(0, 1'b0);
        send_frame(8'd100, 9, 1'b1, 1'b0);
        drain(0, 1'b0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
